// File: rtl/seq_mul_pkg.sv
// Shared arithmetic package for the sequential multiplier and divider.
// It holds the common controller state encoding, the default operand width
// and the iteration counter width.
package seq_mul_pkg;

  localparam int SEQ_MUL_WIDTH = 10;

  // The counter must hold 0 .. w-1. The result is never less than 1 bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int SEQ_MUL_CNT_W = cnt_width(SEQ_MUL_WIDTH);

  // Controller states. The divider controller uses the same encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_mul_if.sv
// start/busy/valid handshake bundle for the sequential multiplier.
//
// Handshake: the block samples start only while it is idle. The rising edge
// where start=1 and the block is idle is the accepting edge, and A/B are
// captured on that edge. busy is high from the accepting edge until the
// result edge. valid is a one-cycle pulse that follows the result edge, and
// P/ov become valid in that same cycle. P and ov then hold until the next
// completion. The block ignores start while busy or while valid is high.
interface seq_mul_if
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = SEQ_MUL_WIDTH
);
  logic                 start;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   P;
  logic                 busy;
  logic                 valid;
  logic                 ov;

  modport master (
    output start, A, B,
    input  P, busy, valid, ov
  );

  modport slave (
    input  start, A, B,
    output P, busy, valid, ov
  );
endinterface

// File: rtl/seq_mul_dp.sv
// Shift-add datapath. It contains the operand registers, the WIDTH+1-bit
// adder, the {acc_hi, mplier} shift register and the iteration counter.
// load captures a new operand pair. Each step performs one iteration.
// prod_next is the full product that the current step would produce.
module seq_mul_dp
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = SEQ_MUL_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 last,
  output logic [2*WIDTH-1:0]   prod_next
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_hi;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   sum;

  // Conditional add into the upper half. The carry is kept in sum[WIDTH].
  always_comb begin
    sum = {1'b0, acc_hi};
    if (mplier[0]) begin
      sum = {1'b0, acc_hi} + {1'b0, mcand};
    end
  end

  // The shift of {carry, acc_hi, mplier} that this step would perform.
  // After the final step, the low half of the product is in mplier.
  assign prod_next = {sum, mplier[WIDTH-1:1]};
  assign last      = (count == CNT_W'(WIDTH - 1));

  // Operand capture on load, then one iteration per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= a_in;
      mplier <= b_in;
      acc_hi <= '0;
      count  <= '0;
    end else if (step) begin
      acc_hi <= sum[WIDTH:1];
      mplier <= {sum[0], mplier[WIDTH-1:1]};
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_mul_top.sv
// Sequential unsigned shift-add multiplier. The controller FSM and the
// output registers live here, and the arithmetic lives in seq_mul_dp.
// The latency is fixed at WIDTH iterations, whatever the operand values.
module seq_mul_top
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = SEQ_MUL_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  seq_mul_if.slave    bus,
  output seq_state_e  state_dbg
);

  seq_state_e         state;
  seq_state_e         next_state;
  logic               load;
  logic               step;
  logic               last;
  logic [2*WIDTH-1:0] prod_next;

  logic [2*WIDTH-1:0] p_q;
  logic               busy_q;
  logic               valid_q;
  logic               ov_q;

  seq_mul_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .a_in      (bus.A),
    .b_in      (bus.B),
    .last      (last),
    .prod_next (prod_next)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath controls. start matters only in IDLE.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output registers. P and ov change only on the completion edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (load) begin
        busy_q <= 1'b1;
      end
      if (step && last) begin
        busy_q  <= 1'b0;
        valid_q <= 1'b1;
        p_q     <= prod_next;
        ov_q    <= |prod_next[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign bus.P     = p_q;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.ov    = ov_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_mul_top.sv
// Bench for seq_mul_top. A transaction-level model derives the expected
// busy, valid, P and ov values from the accept time and from A*B. Directed
// vectors pin the model to hand-computed products.
module tb_seq_mul_top;
  import seq_mul_pkg::*;

  localparam int W = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  seq_state_e state_dbg;

  seq_mul_if #(.WIDTH(W)) bus ();

  seq_mul_top #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the expected queue holds {ov, P} for each accepted transaction.
  logic [2*W:0]   exp_q[$];
  int             cyc_since = -1;   // edges since accept; -1 means idle
  int             edge_cnt  = 0;
  logic [2*W-1:0] m_p  = '0;
  logic           m_ov = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [2*W-1:0] prod;
    logic [2*W:0]   ent;
    if (rst) begin
      cyc_since = -1;
      exp_q.delete();
      m_p  = '0;
      m_ov = 1'b0;
    end else begin
      edge_cnt++;
      if (cyc_since < 0) begin
        if (bus.start === 1'b1) begin
          prod = (2*W)'(bus.A) * (2*W)'(bus.B);
          exp_q.push_back({(prod >= (2*W)'(1 << W)), prod});
          cyc_since = 0;
        end
      end else begin
        cyc_since++;
        if (cyc_since == W) begin
          if (exp_q.size() == 0) begin
            check("sb_entry_present", 64'd0, 64'd1);
          end else begin
            ent  = exp_q.pop_front();
            m_ov = ent[2*W];
            m_p  = ent[2*W-1:0];
          end
        end
        if (cyc_since == W + 1) begin
          cyc_since = -1;
        end
      end
    end
  end

  // Compare process, run on every falling edge.
  always @(negedge clk) begin
    check("busy",  bus.busy,  (cyc_since >= 0 && cyc_since < W));
    check("valid", bus.valid, (cyc_since == W));
    check("P",     bus.P,     m_p);
    check("ov",    bus.ov,    m_ov);
    check("idle_state", (state_dbg == IDLE), (cyc_since < 0));
  end

  // Driver tasks.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, output int acc_edge);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    acc_edge  = edge_cnt + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int acc_edge,
                           input logic [2*W-1:0] lit_p, input logic lit_ov, input bit chk_lit);
    int n = 0;
    while (bus.valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.valid !== 1'b1) begin
      check({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check({name, "_latency"}, 64'(edge_cnt - acc_edge + 1), 64'(W + 1));
      if (chk_lit) begin
        check({name, "_P"},  bus.P,  lit_p);
        check({name, "_ov"}, bus.ov, lit_ov);
      end
    end
  endtask

  // Directed sequence.
  initial begin
    int acc;
    int extra;
    int a, b, q, r;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    repeat (2) @(negedge clk);
    check("rst_P",     bus.P,     64'd0);
    check("rst_busy",  bus.busy,  64'd0);
    check("rst_valid", bus.valid, 64'd0);
    check("rst_ov",    bus.ov,    64'd0);
    check("rst_state", (state_dbg == IDLE), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    start_op(10'd594, 10'd100, acc);
    wait_done("a594_b100", acc, 20'd59400, 1'b1, 1'b1);

    start_op(10'd25, 10'd20, acc);
    wait_done("a25_b20", acc, 20'd500, 1'b0, 1'b1);

    // The second start and the later A/B changes must be ignored.
    start_op(10'd25, 10'd20, acc);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 10'd3;
    bus.B     = 10'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = 10'd999;
    bus.B     = 10'd511;
    wait_done("ignored_start", acc, 20'd500, 1'b0, 1'b1);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.valid === 1'b1) extra++;
    end
    check("no_second_valid", 64'(extra), 64'd0);

    start_op(10'd0, 10'd777, acc);
    wait_done("a0_b777", acc, 20'd0, 1'b0, 1'b1);

    // start asserted during the DONE cycle is ignored.
    bus.start = 1'b1;
    bus.A     = 10'd5;
    bus.B     = 10'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("done_start_busy", bus.busy, 64'd0);
    check("done_start_P",    bus.P,    64'd0);

    start_op(10'd1023, 10'd1023, acc);
    wait_done("a1023_b1023", acc, 20'd1046529, 1'b1, 1'b1);

    // Asynchronous reset during cycle 5 of busy.
    start_op(10'd7, 10'd9, acc);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy",  bus.busy,  64'd0);
    check("arst_valid", bus.valid, 64'd0);
    check("arst_ov",    bus.ov,    64'd0);
    check("arst_P",     bus.P,     64'd0);
    check("arst_state", (state_dbg == IDLE), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_op(10'd2, 10'd3, acc);
    wait_done("post_rst_a2_b3", acc, 20'd6, 1'b0, 1'b1);

    // Divider round trip: Q*B + R must equal A.
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(0, 1023));
      b = int'($urandom_range(1, 1023));
      q = a / b;
      r = a % b;
      start_op(W'(q), W'(b), acc);
      wait_done("roundtrip", acc, '0, 1'b0, 1'b0);
      check("roundtrip_P_plus_R", 64'(bus.P) + 64'(r), 64'(a));
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_mul_top.md
Name: seq_mul_top

Overview:
- Sequential unsigned shift-add multiplier. It is the inverse-operation companion to the 10-bit divider.
- It uses the same start/busy/valid handshake, so the divider's quotient can be multiplied back (Q×B) for self-checking and for datapath reuse.
- It sits beside the divider in the arithmetic subsystem and is driven by the same controller/bench.
- It takes one operand pair per transaction and gives fixed latency independent of operand values.

Parameters:
- WIDTH, 10, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- A  in  WIDTH  multiplicand, captured on the accepting edge
- B  in  WIDTH  multiplier, captured on the accepting edge
- P  out  2*WIDTH  product, registered, held until next completion
- busy  out  1  high while iterating
- valid  out  1  one-cycle completion pulse
- ov  out  1  high when P does not fit in WIDTH bits

Behaviour:
- Interface constraint: one clock (clk); reset rst is asynchronous and active-high.
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE.
  - busy=0, valid=0, ov=0, P=0.
  - Internal count, accumulator and operand registers all cleared.
  - Deassertion takes effect at the next clk edge.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start=1 at a rising edge (edge 0): latch A into mcand and B into mplier, clear accumulator, set count=0, go to CALC. busy=1 from edge 0.
  - If start=0: stay in IDLE; P/ov hold their last values.
- CALC, one iteration per edge:
  - If mplier[0]=1, add mcand to accumulator upper half using a WIDTH+1-bit sum (carry kept).
  - Shift {carry, acc_hi, mplier} right by one.
  - count++.
- CALC exit:
  - On the edge where count reaches WIDTH-1 (the WIDTH-th iteration, edge WIDTH), go to DONE.
  - On that edge, register P={acc_hi,acc_lo}, set ov=|P[2W-1:W], busy=0, valid=1.
- DONE:
  - Lasts exactly one cycle.
  - At the next edge: valid=0, state=IDLE.
  - start is ignored in DONE.
- Latency:
  - valid is observed high in the cycle after edge WIDTH, i.e. WIDTH+1 cycles after the accepting edge.
  - busy is high for exactly WIDTH cycles.
  - Latency is fixed, including zero operands.
- start while busy or in DONE: ignored, with no effect on the operands or the result in flight. A/B changes after acceptance have no effect.
- P and ov update only on a completion edge; they are stable at all other times.
- Arithmetic:
  - Unsigned.
  - Maximum product (2^W-1)^2 fits in 2*WIDTH bits, so there is no truncation.
  - ov mirrors the divider's ov meaning ("result exceeds WIDTH bits").
- Only one transaction is in flight at a time; there is no queueing.

Decomposition:
- Shared arithmetic package:
  - state encoding typedef (IDLE/CALC/DONE), shared with the divider controller;
  - default WIDTH=10 constant;
  - count width constant clog2(WIDTH).
- Natural sub-module: seq_mul_dp, the datapath.
  - Contains the operand registers, the WIDTH+1-bit adder, the shift register and the counter.
  - Exposes load/step/last controls.
- seq_mul_top holds the FSM and the output registers.

Test Plan:
- Basic overflow case: A=594 (10'b1001010010), B=100, start pulse one cycle → busy high 10 cycles, then valid pulse for 1 cycle, P=59400 (0x0E808), ov=1.
- Non-overflow case: A=25, B=20 → P=500, ov=0, valid exactly 11 cycles after the accepting edge.
- Extremes:
  - A=1023, B=1023 → P=1046529 (0xFF801), ov=1.
  - A=0, B=777 → P=0, ov=0, with identical latency (11 cycles).
- Ignored inputs:
  - Assert start again at cycle 4 of busy with new A=3, B=3 → ignored; P=500 for the original 25×20; no second valid.
  - Changing A/B mid-operation likewise has no effect.
- Reset mid-operation:
  - Assert rst asynchronously (mid-cycle) during cycle 5 of busy → busy, valid, ov and P go to 0 immediately without a clock edge.
  - After release, a new start with A=2, B=3 → P=6 after 11 cycles.
- Divider round-trip: feed divider Q and B into this block; check P + remainder = A for 20 random operand pairs with B≠0.
